// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port plus the decoder-facing
// instruction handshake and the redirect/halt controls from execute.
interface instruction_fetch_unit_if #(
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int ADDRESS_WIDTH     = 16
);
   logic                          mem_req;
   logic [ADDRESS_WIDTH-1:0]      mem_addr;
   logic                          mem_ack;
   logic [INSTRUCTION_WIDTH-1:0]  mem_data;

   logic [INSTRUCTION_WIDTH-1:0]  Instruction;
   logic                          is_bios;
   logic                          instr_valid;
   logic                          instr_ready;
   logic [ADDRESS_WIDTH-1:0]      instr_pc;

   logic                          redirect;
   logic [ADDRESS_WIDTH-1:0]      redirect_target;
   logic                          halt;
   logic                          halted;

   modport master (
      output mem_req, mem_addr, Instruction, is_bios, instr_valid, instr_pc, halted,
      input  mem_ack, mem_data, instr_ready, redirect, redirect_target, halt
   );

   modport slave (
      input  mem_req, mem_addr, Instruction, is_bios, instr_valid, instr_pc, halted,
      output mem_ack, mem_data, instr_ready, redirect, redirect_target, halt
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests one word at a time, holds it for decode,
// and follows redirects and halt from the execute stage.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_REQUEST | mem_req high at pc, waiting for mem_ack
// ST_HOLD    | fetched word presented to decode until instr_ready
// ST_HALTED  | fetch stopped after HLT; only redirect or reset resumes
module instruction_fetch_unit #(
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int ADDRESS_WIDTH     = 16,
   parameter int OS_START          = 2048,
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = INSTRUCTION_WIDTH'(16'hE000)
) (
   input  logic                      clock,
   input  logic                      reset,
   instruction_fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {
      ST_REQUEST = 2'd0,
      ST_HOLD    = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] OS_START_ADDR = ADDRESS_WIDTH'(OS_START);

   state_t                         state;
   logic [ADDRESS_WIDTH-1:0]       pc;
   logic [ADDRESS_WIDTH-1:0]       instr_pc_q;
   logic [INSTRUCTION_WIDTH-1:0]   instruction_q;
   logic                           instr_valid_q;
   logic                           is_bios_q;
   logic                           mem_req_q;
   logic                           halted_q;
   logic [ADDRESS_WIDTH-1:0]       pc_seq;
   logic                           accept;

   // Wraps naturally at the address width.
   assign pc_seq = instr_pc_q + ADDRESS_WIDTH'(1);
   assign accept = (state == ST_HOLD) && instr_valid_q && bus.instr_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_REQUEST;
         pc            <= '0;
         instr_pc_q    <= '0;
         instruction_q <= NOP_WORD;
         instr_valid_q <= 1'b0;
         is_bios_q     <= 1'b1;
         mem_req_q     <= 1'b1;
         halted_q      <= 1'b0;
      end else if (bus.redirect) begin
         // Redirect beats halt and discards any ack or accept this cycle.
         state         <= ST_REQUEST;
         pc            <= bus.redirect_target;
         instruction_q <= NOP_WORD;
         instr_valid_q <= 1'b0;
         mem_req_q     <= 1'b1;
         halted_q      <= 1'b0;
      end else if (bus.halt) begin
         if (accept) begin
            pc <= pc_seq;
         end
         state         <= ST_HALTED;
         instruction_q <= NOP_WORD;
         instr_valid_q <= 1'b0;
         mem_req_q     <= 1'b0;
         halted_q      <= 1'b1;
      end else begin
         case (state)
            ST_REQUEST: begin
               if (bus.mem_ack) begin
                  instruction_q <= bus.mem_data;
                  instr_pc_q    <= pc;
                  is_bios_q     <= (pc < OS_START_ADDR);
                  instr_valid_q <= 1'b1;
                  mem_req_q     <= 1'b0;
                  state         <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (accept) begin
                  pc            <= pc_seq;
                  instruction_q <= NOP_WORD;
                  instr_valid_q <= 1'b0;
                  mem_req_q     <= 1'b1;
                  state         <= ST_REQUEST;
               end
            end
            ST_HALTED: begin
               mem_req_q <= 1'b0;
               halted_q  <= 1'b1;
            end
            default: begin
               state         <= ST_REQUEST;
               instruction_q <= NOP_WORD;
               instr_valid_q <= 1'b0;
               mem_req_q     <= 1'b1;
               halted_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = pc;
   assign bus.Instruction = instruction_q;
   assign bus.is_bios     = is_bios_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic,
// with captured words queued by the driver and checked by a separate monitor.
module tb_instruction_fetch_unit;

   localparam int          IW  = 16;
   localparam int          AW  = 16;
   localparam int          OS  = 2048;
   localparam logic [15:0] NOP = 16'hE000;

   logic clock = 1'b0;
   logic reset = 1'b1;

   instruction_fetch_unit_if #(.INSTRUCTION_WIDTH(IW), .ADDRESS_WIDTH(AW)) bus ();

   instruction_fetch_unit #(
      .INSTRUCTION_WIDTH(IW),
      .ADDRESS_WIDTH(AW),
      .OS_START(OS),
      .NOP_WORD(NOP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] data;
      logic        bios;
   } word_t;

   word_t sbq[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   // Reference model: next fetch address, whether a word is held, halted.
   bit          known     = 1'b0;
   bit          after_rst = 1'b0;
   bit          m_hold    = 1'b0;
   bit          m_halt    = 1'b0;
   logic [15:0] m_pc      = 16'h0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] pick_target();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'd2046;
         2:       return 16'd2047;
         3:       return 16'd2048;
         4:       return 16'hFFFE;
         5:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor: each newly presented word must match the next queued capture.
   logic        prev_valid = 1'b0;
   logic [15:0] last_instr, last_pc;
   logic        last_bios;

   always @(negedge clock) begin
      word_t w;
      if (bus.instr_valid === 1'b1 && prev_valid !== 1'b1) begin
         chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            w = sbq.pop_front();
            chk("instruction", 32'(bus.Instruction), 32'(w.data));
            chk("instr_pc",    32'(bus.instr_pc),    32'(w.pc));
            chk("is_bios",     32'(bus.is_bios),     32'(w.bios));
         end
      end else if (bus.instr_valid === 1'b1) begin
         chk("hold_instr_stable", 32'(bus.Instruction), 32'(last_instr));
         chk("hold_pc_stable",    32'(bus.instr_pc),    32'(last_pc));
         chk("hold_bios_stable",  32'(bus.is_bios),     32'(last_bios));
      end else if (bus.instr_valid === 1'b0) begin
         chk("nop_when_invalid", 32'(bus.Instruction), 32'(NOP));
      end
      prev_valid = bus.instr_valid;
      last_instr = bus.Instruction;
      last_pc    = bus.instr_pc;
      last_bios  = bus.is_bios;
   end

   // One cycle: check outputs against the model, drive inputs, advance model.
   task automatic step(input bit ack, input logic [15:0] data, input bit ready,
                       input bit redir, input logic [15:0] tgt, input bit hlt,
                       input bit rst);
      @(negedge clock);
      if (known) begin
         chk("mem_req",     32'(bus.mem_req),     32'(!m_hold && !m_halt));
         if (!m_hold && !m_halt)
            chk("mem_addr", 32'(bus.mem_addr),    32'(m_pc));
         chk("halted",      32'(bus.halted),      32'(m_halt));
         chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold));
         if (after_rst) begin
            chk("rst_instr_pc",    32'(bus.instr_pc),    32'd0);
            chk("rst_is_bios",     32'(bus.is_bios),     32'd1);
            chk("rst_instruction", 32'(bus.Instruction), 32'(NOP));
         end
      end
      reset               = rst;
      bus.mem_ack         = ack;
      bus.mem_data        = data;
      bus.instr_ready     = ready;
      bus.redirect        = redir;
      bus.redirect_target = tgt;
      bus.halt            = hlt;
      if (rst) begin
         m_pc      = 16'h0;
         m_hold    = 1'b0;
         m_halt    = 1'b0;
         known     = 1'b1;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         if (known) begin
            if (redir) begin
               m_pc   = tgt;
               m_hold = 1'b0;
               m_halt = 1'b0;
            end else if (hlt) begin
               if (m_hold && ready) m_pc = m_pc + 16'd1;
               m_hold = 1'b0;
               m_halt = 1'b1;
            end else if (!m_halt) begin
               if (!m_hold) begin
                  if (ack) begin
                     m_hold = 1'b1;
                     sbq.push_back('{pc: m_pc, data: data, bios: (m_pc < 16'(OS))});
                  end
               end else if (ready) begin
                  m_hold = 1'b0;
                  m_pc   = m_pc + 16'd1;
               end
            end
         end
      end
   endtask

   task automatic idle(input int n, input bit ready);
      for (int i = 0; i < n; i++)
         step(1'b0, 16'($urandom), ready, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.mem_ack = 1'b0; bus.mem_data = '0; bus.instr_ready = 1'b0;
      bus.redirect = 1'b0; bus.redirect_target = '0; bus.halt = 1'b0;

      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      // First fetch after reset, then hold with decode stalled.
      step(1'b1, 16'h2105, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(5, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2, 1'b0);
      // Redirect collides with ack: word dropped, OS region fetched.
      step(1'b1, 16'h1234, 1'b0, 1'b1, 16'd2048, 1'b0, 1'b0);
      step(1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Redirect while holding with ready: accept ignored; then wrap at FFFF.
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      step(1'b1, 16'h0BAD, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      // Halt during request with ack dropped; acks while halted ignored.
      step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         step(1'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
      step(1'b1, 16'h4321, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Halt while accepting, then redirect+halt together.
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      idle(3, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0300, 1'b1, 1'b0);
      step(1'b1, 16'h6060, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      // Reset mid-request with ack present.
      step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      idle(2, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 99) < 50), 16'($urandom),
              ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 99) < 5), pick_target(),
              ($urandom_range(0, 99) < 4),
              ($urandom_range(0, 299) == 0));
      end
      idle(3, 1'b0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clock and reset.
REQ-002 Parameter INSTRUCTION_WIDTH, default 16: instruction word width.
REQ-003 Parameter ADDRESS_WIDTH, default 16: word-address width of the program counter.
REQ-004 Parameter OS_START, default 2048: first OS word address; lower addresses are BIOS.
REQ-005 Parameter NOP_WORD, default 16'hE000: instruction presented when no valid word is held.
REQ-006 Port: clock  input  1  rising-edge clock.
REQ-007 Port: reset  input  1  synchronous active-high reset.
REQ-008 Port: mem_req  output  1  instruction memory read request.
REQ-009 Port: mem_addr  output  ADDRESS_WIDTH  word address of request.
REQ-010 Port: mem_ack  input  1  memory returns mem_data this cycle.
REQ-011 Port: mem_data  input  INSTRUCTION_WIDTH  fetched word.
REQ-012 Port: Instruction  output  INSTRUCTION_WIDTH  registered word to decoder.
REQ-013 Port: is_bios  output  1  registered; high when the held word's address < OS_START.
REQ-014 Port: instr_valid  output  1  Instruction holds a fetched word.
REQ-015 Port: instr_ready  input  1  decode/execute accepts Instruction this cycle.
REQ-016 Port: instr_pc  output  ADDRESS_WIDTH  address of the held word.
REQ-017 Port: redirect  input  1  branch taken; restart fetch at redirect_target.
REQ-018 Port: redirect_target  input  ADDRESS_WIDTH  new fetch address.
REQ-019 Port: halt  input  1  stop fetching (HLT executed).
REQ-020 Port: halted  output  1  block is in HALTED.

Function
REQ-021 States SHALL be REQUEST, HOLD, HALTED; state is registered.
REQ-022 REQUEST: mem_req=1, mem_addr=pc, both stable until mem_ack; on mem_ack, capture mem_data into Instruction, pc into instr_pc, (pc<OS_START) into is_bios, set instr_valid, go to HOLD.
REQ-023 A single-cycle mem_ack in the first REQUEST cycle SHALL give instr_valid=1 on the next cycle (one-cycle fetch latency).
REQ-024 HOLD: mem_req=0; when instr_valid and instr_ready, clear instr_valid, set pc=instr_pc+1, go to REQUEST.
REQ-025 pc increment SHALL wrap modulo 2^ADDRESS_WIDTH (all-ones -> 0).
REQ-026 Instruction, instr_pc, is_bios SHALL not change while instr_valid=1 and instr_ready=0.
REQ-027 When instr_valid=0, Instruction SHALL read NOP_WORD.
REQ-028 redirect=1 in REQUEST or HOLD: next cycle pc=redirect_target, instr_valid=0, state REQUEST; mem_ack/instr_ready in the same cycle are ignored (no capture, no increment).
REQ-029 redirect=1 in HALTED SHALL resume: next cycle pc=redirect_target, state REQUEST.
REQ-030 halt=1 (without redirect) in any state: next cycle state HALTED, instr_valid=0, mem_req=0; an in-flight mem_ack that cycle is dropped; pc keeps instr_pc+1 if instr_ready accepted that cycle, else unchanged.
REQ-031 redirect and halt in the same cycle: redirect wins.
REQ-032 HALTED: mem_req=0, halted=1, instr_valid=0; stays until redirect or reset.
REQ-033 mem_ack outside REQUEST SHALL be ignored.

Reset
REQ-034 reset=1 at a rising edge SHALL set: pc=0, state REQUEST, instr_valid=0, Instruction=NOP_WORD, instr_pc=0, is_bios=1, halted=0; mem_req=1 from the first cycle after reset deasserts.
REQ-035 reset SHALL override redirect, halt and mem_ack, including mid-fetch; a mem_ack during reset is dropped.

Verification
REQ-036 Reset then mem_ack with mem_data=16'h2105 one cycle later -> mem_addr=0; next cycle instr_valid=1, Instruction=16'h2105, instr_pc=0, is_bios=1.
REQ-037 instr_ready held 0 for 5 cycles with word held -> Instruction/instr_pc stable, mem_req=0; ready=1 -> next cycle mem_req=1, mem_addr=1.
REQ-038 redirect to 2048 in the same cycle as mem_ack -> word discarded, next mem_addr=2048; fetched word gives is_bios=0.
REQ-039 pc=16'hFFFF accepted -> next mem_addr=0.
REQ-040 halt during REQUEST -> halted=1, mem_req=0 indefinitely; redirect to 16'h0010 -> mem_req=1, mem_addr=16'h0010; redirect+halt together -> fetch continues at target.
REQ-041 reset asserted mid-REQUEST with mem_ack=1 -> no capture; outputs at REQ-034 values.
